// File: rtl/mux_q1_pkg.sv
// mux_q1_pkg: shared op codes, feeder FSM states and command-word sizing.
package mux_q1_pkg;
  localparam logic [1:0] OP_ZERO = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_EVEN = 2'b11;
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  function automatic int cmd_w(input int data_w);
    return 2 + 2 * data_w;
  endfunction
endpackage

// File: rtl/mux_q1_cmd_fifo.sv
// mux_q1_cmd_fifo: synchronous FIFO holding packed {op,x,y} commands.
module mux_q1_cmd_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;
  assign full    = count == CNT_W'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= (do_push && !do_pop) ? count + 1'b1 :
               (do_pop && !do_push) ? count - 1'b1 : count;
    end
  end
endmodule

// File: rtl/mux_q1_cmd_feeder.sv
// mux_q1_cmd_feeder: buffers commands, drives mux_Q1 operands, returns its result.
module mux_q1_cmd_feeder
  import mux_q1_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_y,
  output logic [1:0]        s0,
  output logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y,
  input  logic [DATA_W-1:0] z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_z,
  output logic [1:0]        out_op,
  output logic [CNT_W-1:0]  count
);
  localparam int CW = cmd_w(DATA_W);
  state_t        state, state_n;
  logic          full, empty, pop;
  logic [CW-1:0] rdata;
  mux_q1_cmd_fifo #(.W(CW), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk(clk), .rst(rst), .push(in_valid), .wdata({in_op, in_x, in_y}),
    .pop(pop), .rdata(rdata), .full(full), .empty(empty), .count(count)
  );
  assign in_ready = !full;
  always_comb begin
    pop     = !empty && (state == IDLE || (state == HOLD && out_ready));
    state_n = state == ISSUE ? HOLD :
              pop ? ISSUE :
              (state == HOLD && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // z is a pure function of the registered operands, so it is stable by ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      s0        <= '0;
      x         <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      out_z     <= '0;
      out_op    <= '0;
    end else begin
      if (pop) {s0, x, y} <= rdata;
      if (state == ISSUE) begin
        out_z     <= z;
        out_op    <= s0;
        out_valid <= 1'b1;
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mux_q1_cmd_feeder.sv
// tb_mux_q1_cmd_feeder: scoreboard bench with a behavioural mux_Q1 in the loop.
module tb_mux_q1_cmd_feeder;
  logic       clk = 1'b0, rst = 1'b1;
  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [1:0] in_op = '0, s0, out_op;
  logic [7:0] in_x = '0, in_y = '0, x, y, z, out_z;
  logic [2:0] count;
  int         tests = 0, fails = 0, cyc = 0, nres = 0;
  logic [9:0] sb[$];
  int         hs[$];

  mux_q1_cmd_feeder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_x(in_x), .in_y(in_y), .s0(s0), .x(x), .y(y), .z(z),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_op(out_op), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_z(input logic [1:0] op, input logic [7:0] a, b);
    return op == 2'b00 ? 8'd0 : op == 2'b01 ? a + b : op == 2'b10 ? a ^ b : {7'd0, ~a[0]};
  endfunction

  always_comb z = ref_z(s0, x, y);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [9:0] e;
    cyc++;
    if (rst) sb.delete();
    else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = sb.pop_front();
          chk("out_op", 32'(out_op), 32'(e[9:8]));
          chk("out_z", 32'(out_z), 32'(e[7:0]));
        end
        hs.push_back(cyc);
        nres++;
      end
      if (in_valid && in_ready) sb.push_back({in_op, ref_z(in_op, in_x, in_y)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1; in_op = op; in_x = a; in_y = b;
    while (!in_ready && n < 100) begin step(); n++; end
    if (n >= 100) chk("send_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin step(); n++; end
    chk("drain_done", 32'(n < 200), 1);
  endtask

  initial begin
    int acc, n0;
    logic [7:0] zh;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_ops", {s0, x, y, out_z, out_op}, 0);
    rst = 1'b0;
    // single add: operands one edge after push, result one edge later
    out_ready = 1'b1;
    send(2'b01, 8'd9, 8'd5);
    chk("lat_out_valid0", 32'(out_valid), 0);
    step();
    chk("issue_s0", 32'(s0), 1);
    chk("issue_x", 32'(x), 9);
    chk("issue_y", 32'(y), 5);
    chk("issue_out_valid", 32'(out_valid), 0);
    step();
    chk("lat_out_valid", 32'(out_valid), 1);
    chk("lat_out_z", 32'(out_z), 14);
    chk("lat_out_op", 32'(out_op), 1);
    drain();
    // back-to-back: one result every 2 cycles
    hs.delete();
    send(2'b00, 8'd9, 8'd5);
    send(2'b10, 8'd9, 8'd5);
    send(2'b11, 8'd9, 8'd5);
    drain();
    chk("b2b_results", hs.size(), 3);
    if (hs.size() == 3) begin
      chk("b2b_gap1", hs[1] - hs[0], 2);
      chk("b2b_gap2", hs[2] - hs[1], 2);
    end
    send(2'b11, 8'd3, 8'd7);
    send(2'b11, 8'd4, 8'd7);
    drain();
    // backpressure: DEPTH in FIFO plus one in the operand register
    out_ready = 1'b0;
    acc = 0;
    n0 = nres;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_op = 2'((i + 1) % 4); in_x = 8'(i * 10 + 3); in_y = 8'(i + 1);
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    chk("bp_accepted", acc, 5);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_count", 32'(count), 4);
    chk("bp_out_valid", 32'(out_valid), 1);
    chk("bp_first_z", 32'(out_z), 4);
    zh = out_z;
    repeat (3) step();
    chk("bp_stable_z", 32'(out_z), 32'(zh));
    chk("bp_stable_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    step();
    chk("rel_count", 32'(count), 3);
    chk("rel_in_ready", 32'(in_ready), 1);
    drain();
    chk("rel_results", nres - n0, 5);
    // simultaneous push and pop at count=2
    out_ready = 1'b0;
    send(2'b01, 8'd200, 8'd100);
    send(2'b10, 8'hAA, 8'h0F);
    send(2'b01, 8'd1, 8'd2);
    chk("pp_pre_count", 32'(count), 2);
    chk("pp_pre_valid", 32'(out_valid), 1);
    in_valid = 1'b1; in_op = 2'b11; in_x = 8'd6; in_y = 8'd1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("pp_count", 32'(count), 2);
    drain();
    // reset in HOLD with count=3
    out_ready = 1'b0;
    send(2'b01, 8'd10, 8'd20);
    send(2'b10, 8'd7, 8'd1);
    send(2'b01, 8'd5, 8'd5);
    send(2'b00, 8'd1, 8'd1);
    chk("mr_pre_count", 32'(count), 3);
    chk("mr_pre_valid", 32'(out_valid), 1);
    rst = 1'b1;
    step();
    chk("mr_out_valid", 32'(out_valid), 0);
    chk("mr_count", 32'(count), 0);
    chk("mr_ops", {s0, x, y}, 0);
    chk("mr_in_ready", 32'(in_ready), 1);
    rst = 1'b0;
    out_ready = 1'b1;
    n0 = nres;
    repeat (10) step();
    chk("mr_no_stale", nres - n0, 0);
    chk("mr_idle_valid", 32'(out_valid), 0);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
